// File: rtl/mul_csa_pipe_pkg.sv
// ------------------------------------------------------------------
// mul_csa_pipe_pkg : widths and Booth select encodings for mul_csa_pipe
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mul_csa_pipe_pkg;

  localparam int MUL_W  = 32;
  localparam int RES_W  = 64;
  localparam int PP_NUM = 17;
  localparam int MAG_W  = MUL_W + 2;
  localparam int PP_W   = 66;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M1   = 3'd3,
    BOOTH_M2   = 3'd4
  } booth_sel_e;

  // Group is {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_sel_e booth_decode(input logic [2:0] grp);
    case (grp)
      3'b001, 3'b010: return BOOTH_P1;
      3'b011:         return BOOTH_P2;
      3'b100:         return BOOTH_M2;
      3'b101, 3'b110: return BOOTH_M1;
      default:        return BOOTH_ZERO;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_pp_gen.sv
// ------------------------------------------------------------------
// booth_pp_gen : radix-4 Booth partial product, pre-shifted, with negate flag
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module booth_pp_gen
  import mul_csa_pipe_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [2:0]      grp,
  input  logic [MUL_W:0]  a,
  output logic [PP_W-1:0] pp,
  output logic            neg
);

  booth_sel_e       sel;
  logic [MAG_W-1:0] mag;
  logic [PP_W-1:0]  ext;

  assign sel = booth_decode(grp);

  always_comb begin
    mag = '0;
    case (sel)
      BOOTH_P1, BOOTH_M1: mag = {a[MUL_W], a};
      BOOTH_P2, BOOTH_M2: mag = {a, 1'b0};
      default:            mag = '0;
    endcase
  end

  assign neg = (sel == BOOTH_M1) || (sel == BOOTH_M2);

  // Ones' complement only; the +1 of the negation is injected at bit SHIFT in the tree
  assign ext = {{(PP_W - MAG_W){mag[MAG_W-1]}}, mag} ^ {PP_W{neg}};
  assign pp  = ext << SHIFT;

endmodule

`default_nettype wire

// File: rtl/full_add.sv
// ------------------------------------------------------------------
// full_add : single-bit 3:2 carry-save cell
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

`default_nettype wire

// File: rtl/half_add.sv
// ------------------------------------------------------------------
// half_add : single-bit 2:2 cell
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module half_add (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

`default_nettype wire

// File: rtl/mul_csa_pipe_tree.sv
// ------------------------------------------------------------------
// mul_csa_pipe_tree : Booth partial products reduced to sum/carry rows
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mul_csa_pipe_tree
  import mul_csa_pipe_pkg::*;
(
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  input  logic             sgn,
  output logic [RES_W-1:0] sum,
  output logic [RES_W-1:0] carry
);

  localparam int ROWS = PP_NUM + 1;
  localparam int LVLS = ROWS - 2;

  logic [MUL_W:0]              ax;
  logic [MUL_W+1:0]            bx;
  logic [MUL_W+2:0]            bg;
  logic [PP_NUM-1:0][PP_W-1:0] pp;
  logic [PP_NUM-1:0]           neg;
  logic [PP_NUM-1:0]           pp_spare;
  logic [RES_W-1:0]            inj;
  logic [ROWS-1:0][RES_W-1:0]  rows;
  logic [LVLS:0][RES_W-1:0]    s_row;
  logic [LVLS:0][RES_W-1:0]    c_row;
  logic [LVLS-1:0]             lvl_spare;
  logic                        unused_bits;

  assign ax = {sgn & a[MUL_W-1], a};
  assign bx = {{2{sgn & b[MUL_W-1]}}, b};
  assign bg = {bx, 1'b0};

  for (genvar i = 0; i < PP_NUM; i++) begin : g_pp
    booth_pp_gen #(.SHIFT(2 * i)) u_pp (
      .grp (bg[2*i+2 -: 3]),
      .a   (ax),
      .pp  (pp[i]),
      .neg (neg[i])
    );
    assign rows[i]     = pp[i][RES_W-1:0];
    assign pp_spare[i] = ^pp[i][PP_W-1:RES_W];
  end

  // Negation carry-ins land on distinct even columns, so they share one row
  always_comb begin
    inj = '0;
    for (int i = 0; i < PP_NUM; i++) inj[2*i] = neg[i];
  end
  assign rows[ROWS-1] = inj;

  assign s_row[0] = rows[0];
  assign c_row[0] = rows[1];

  // Carry rows are always zero in column 0, so that column only needs a half adder
  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    logic [RES_W-1:0] ns;
    logic [RES_W-1:0] co;
    for (genvar j = 0; j < RES_W; j++) begin : g_bit
      if (j == 0) begin : g_ha
        half_add u_ha (
          .a (s_row[k][j]),
          .b (rows[k+2][j]),
          .s (ns[j]),
          .c (co[j])
        );
      end else begin : g_fa
        full_add u_fa (
          .a  (s_row[k][j]),
          .b  (c_row[k][j]),
          .ci (rows[k+2][j]),
          .s  (ns[j]),
          .co (co[j])
        );
      end
    end
    assign s_row[k+1]   = ns;
    assign c_row[k+1]   = {co[RES_W-2:0], 1'b0};
    assign lvl_spare[k] = co[RES_W-1] ^ c_row[k][0];
  end

  assign sum         = s_row[LVLS];
  assign carry       = c_row[LVLS];
  assign unused_bits = ^{lvl_spare, pp_spare};

endmodule

`default_nettype wire

// File: rtl/mul_csa_pipe.sv
// ------------------------------------------------------------------
// mul_csa_pipe : two-stage 32x32 signed/unsigned multiplier, valid/ready
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mul_csa_pipe
  import mul_csa_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [MUL_W-1:0] in_a,
  input  logic [MUL_W-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result
);

  logic             s1_valid;
  logic [RES_W-1:0] s1_sum;
  logic [RES_W-1:0] s1_carry;
  logic [RES_W-1:0] tree_sum;
  logic [RES_W-1:0] tree_carry;
  logic             s1_adv;
  logic             in_fire;
  logic             s1_fire;

  mul_csa_pipe_tree u_tree (
    .a     (in_a),
    .b     (in_b),
    .sgn   (in_signed),
    .sum   (tree_sum),
    .carry (tree_carry)
  );

  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = ~flush & (~s1_valid | s1_adv);
  assign in_fire  = in_valid & in_ready;
  assign s1_fire  = s1_valid & s1_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_fire)     s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv)      out_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sum     <= '0;
      s1_carry   <= '0;
      out_result <= '0;
    end else begin
      if (in_fire) begin
        s1_sum   <= tree_sum;
        s1_carry <= tree_carry;
      end
      if (s1_fire) out_result <= s1_sum + s1_carry;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_csa_pipe.sv
// ------------------------------------------------------------------
// tb_mul_csa_pipe : scoreboard bench for mul_csa_pipe
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mul_csa_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [63:0] out_result;

  always #5 clk = ~clk;

  mul_csa_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int n_checks = 0, n_pass = 0;
  int n_push = 0, n_pop = 0, n_drop = 0;

  function automatic logic [63:0] ref_mul(logic s, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    return 64'(sa * sb);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Stimulus side: every accepted beat pushes its expected product
  always @(negedge clk) begin
    if (!reset && in_valid && in_ready) begin
      exp_q.push_back(ref_mul(in_signed, in_a, in_b));
      n_push++;
    end
  end

  // Monitor: consume results in order; flush/reset discard whatever is in flight
  always @(negedge clk) begin
    if (reset) begin
      n_drop += exp_q.size();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_result);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got %h with no beat outstanding", out_result);
        end else begin
          check("result", out_result, exp_q.pop_front());
        end
        n_pop++;
      end
      if (flush) begin
        n_drop += exp_q.size();
        exp_q.delete();
      end
    end
  end

  task automatic send(logic s, logic [31:0] a, logic [31:0] b, bit rnd);
    logic ok;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 511) == 0);
      end
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    $display("FAIL send_timeout: beat not accepted in 1000 cycles");
    in_valid = 1'b0;
  endtask

  task automatic idle(int n, bit rnd);
    repeat (n) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    n_checks++;
    $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
  endtask

  function automatic logic [31:0] pick_op();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hAAAAAAAA};
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_result", out_result, 0);
    check("reset_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Result visible in the second cycle after the one presenting the beat
    send(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("lat_not_yet", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_out_valid", out_valid, 1);
    check("uns_ffff_sq", out_result, 64'hFFFFFFFE_00000001);
    drain();

    got_q.delete();
    send(1'b1, 32'h80000000, 32'h80000000, 1'b0);
    send(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    send(1'b1, 32'hFFFFFFFD, 32'h00000005, 1'b0);
    send(1'b0, 32'hFFFFFFFD, 32'h00000005, 1'b0);
    drain();
    check("dir_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("sgn_min_sq", got_q[0], 64'h40000000_00000000);
      check("sgn_m1_sq", got_q[1], 64'h1);
      check("sgn_m3x5", got_q[2], 64'hFFFFFFFF_FFFFFFF1);
      check("uns_m3x5", got_q[3], 64'h00000004_FFFFFFF1);
    end

    // Backpressure: two beats fill both stages, the third must wait
    got_q.delete();
    out_ready = 1'b0;
    send(1'b0, 32'd11, 32'd13, 1'b0);
    send(1'b1, 32'hFFFFFFF0, 32'd7, 1'b0);
    in_signed = 1'b0; in_a = 32'd100; in_b = 32'd200; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("full_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1'b0, 32'd100, 32'd200, 1'b0);
    send(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    drain();
    check("bp_count", got_q.size(), 4);
    if (got_q.size() == 4) check("bp_third", got_q[2], 64'd20000);

    // Flush with both stages full
    out_ready = 1'b0;
    send(1'b0, 32'd3, 32'd5, 1'b0);
    send(1'b0, 32'd7, 32'd9, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("flush_no_stale", out_valid, 0);
    end
    send(1'b1, 32'hFFFFFFFE, 32'd21, 1'b0);
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(1'b0, 32'hDEADBEEF, 32'h0BADF00D, 1'b0);
    send(1'b1, 32'hCAFEBABE, 32'h55555555, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    got_q.delete();
    send(1'b1, 32'h12345678, 32'hFEDCBA98, 1'b0);
    drain();
    check("post_rst_count", got_q.size(), 1);
    if (got_q.size() == 1) check("post_rst_result", got_q[0], ref_mul(1'b1, 32'h12345678, 32'hFEDCBA98));

    // Random traffic with random backpressure and occasional flush
    for (int n = 0; n < 10000; n++) begin
      idle($urandom_range(0, 1), 1'b1);
      send(1'($urandom_range(0, 1)), pick_op(), pick_op(), 1'b1);
    end
    flush = 1'b0;
    drain();
    check("count_in_out", n_push, n_pop + n_drop);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
